// File: rtl/ravan_mem_reader.sv
// ravan_mem_reader: burst reader from encrypted-data memory into a 2-entry FIFO feeding the decryption core.
// Optional macro RAVAN_RD_TIMEOUT_EN adds a consumer-stall timeout that sets sticky err and aborts the burst.
module ravan_mem_reader #(
  parameter int MEM_LAT = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] base_addr,
  input  logic [15:0] len,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [63:0] mem_rdata,
  output logic [63:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t             state;
  logic [15:0]        addr;
  logic [15:0]        remain;
  logic [MEM_LAT-1:0] pipe;
  logic [63:0]        fifo [2];
  logic               wp;
  logic               rp;
  logic [1:0]         count;
  logic [2:0]         inflight;
  logic               pop;
  logic               push;
  logic               issue;
  logic               kill;
  logic               tmo;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + {2'b0, pipe[i]};
  end

  assign dout_valid = count != 2'd0;
  assign dout       = fifo[rp];
  assign pop        = dout_valid && dout_ready;
  assign kill       = (abort || tmo) && state != IDLE;
  assign push       = pipe[MEM_LAT-1] && !kill;
  // A word leaving the FIFO this cycle frees its slot, which is what sustains one word per cycle at MEM_LAT=1.
  assign issue      = state == RUN && !kill && ({1'b0, count} + inflight - {2'b0, pop}) < 3'd2;
  assign mem_rd_en  = issue;
  assign mem_addr   = addr;
  assign busy       = state != IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr    <= '0;
      remain  <= '0;
      pipe    <= '0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      count   <= 2'd0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      pipe[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1] && !kill;
      if (push) begin
        fifo[wp] <= mem_rdata;
        wp       <= !wp;
      end
      if (pop) rp <= !rp;
      count <= kill ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
      if (kill) begin
        wp <= 1'b0;
        rp <= 1'b0;
      end
      if (issue) begin
        addr   <= addr + 16'd1;
        remain <= remain - 16'd1;
      end
      case (state)
        IDLE: if (start) begin
          if (len != 16'd0) begin
            state  <= RUN;
            addr   <= base_addr;
            remain <= len;
          end else done <= 1'b1;
        end
        RUN: if (kill) state <= IDLE;
        else if (issue && remain == 16'd1) state <= DRAIN;
        DRAIN: if (kill) state <= IDLE;
        else if (pop && count == 2'd1 && inflight == 3'd0) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAVAN_RD_TIMEOUT_EN
  logic [31:0] stall_cnt;
  logic        err_q;
  assign tmo = dout_valid && !dout_ready && stall_cnt == 32'(TIMEOUT - 1);
  assign err = err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      stall_cnt <= (dout_valid && !dout_ready && !kill) ? stall_cnt + 32'd1 : '0;
      if (kill && tmo) err_q <= 1'b1;
      else if (state == IDLE && start) err_q <= 1'b0;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ravan_mem_reader.sv
// tb_ravan_mem_reader: table-driven bursts on a MEM_LAT=1 and a MEM_LAT=3 reader sharing one stimulus stream.
module tb_ravan_mem_reader;
  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    bit          toggle;
    int          exp_n;
    int          exp_span;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] base = '0;
  logic [15:0] len = '0;
  wire  [1:0]  rd_en;
  wire  [1:0]  vld;
  wire  [1:0]  busy;
  wire  [1:0]  done;
  wire  [1:0]  err;
  wire  [15:0] addr_w [2];
  wire  [63:0] dout_w [2];
  logic [63:0] ra;
  logic [63:0] rb0;
  logic [63:0] rb1;
  logic [63:0] rb2;
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        vecs [7];

  int          rd_n [2];
  int          wd_n [2];
  int          done_n [2];
  int          done_t [2];
  int          first_rd [2];
  int          last_rd [2];
  int          first_wd [2];
  int          last_wd [2];
  int          max_out [2];
  bit          busy_seen [2];
  bit          prev_stall [2];
  logic [63:0] prev_dout [2];
  logic [15:0] cur_base;

  always #5 clk = ~clk;

  ravan_mem_reader #(.MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base), .len(len),
    .mem_rd_en(rd_en[0]), .mem_addr(addr_w[0]), .mem_rdata(ra), .dout(dout_w[0]),
    .dout_valid(vld[0]), .dout_ready(ready), .busy(busy[0]), .done(done[0]), .err(err[0]));

  ravan_mem_reader #(.MEM_LAT(3), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base), .len(len),
    .mem_rd_en(rd_en[1]), .mem_addr(addr_w[1]), .mem_rdata(rb2), .dout(dout_w[1]),
    .dout_valid(vld[1]), .dout_ready(ready), .busy(busy[1]), .done(done[1]), .err(err[1]));

  function automatic logic [63:0] f(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
  endfunction

  // Memory models: the data for the address presented now appears MEM_LAT cycles later.
  always @(posedge clk) begin
    ra  <= f(addr_w[0]);
    rb0 <= f(addr_w[1]);
    rb1 <= rb0;
    rb2 <= rb1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      rd_n[d] = 0; wd_n[d] = 0; done_n[d] = 0; done_t[d] = -1;
      first_rd[d] = -1; last_rd[d] = -1; first_wd[d] = -1; last_wd[d] = -1;
      max_out[d] = 0; busy_seen[d] = 0; prev_stall[d] = 0; prev_dout[d] = '0;
    end
  endtask

  task automatic mon(input int t);
    for (int d = 0; d < 2; d++) begin
      if (prev_stall[d]) begin
        chk("hold_valid", 64'(vld[d]), 64'd1);
        chk("hold_dout", dout_w[d], prev_dout[d]);
      end
      if (rd_en[d]) begin
        chk("rd_addr", 64'(addr_w[d]), 64'(16'(cur_base + rd_n[d])));
        if (rd_n[d] == 0) first_rd[d] = t;
        last_rd[d] = t;
        rd_n[d]++;
      end
      if (vld[d] && ready) begin
        chk("word", dout_w[d], f(16'(cur_base + wd_n[d])));
        if (wd_n[d] == 0) first_wd[d] = t;
        last_wd[d] = t;
        wd_n[d]++;
      end
      if (rd_n[d] - wd_n[d] > max_out[d]) max_out[d] = rd_n[d] - wd_n[d];
      if (done[d]) begin
        done_n[d]++;
        done_t[d] = t;
      end
      if (busy[d]) busy_seen[d] = 1;
      prev_stall[d] = vld[d] && !ready && !abort;
      prev_dout[d] = dout_w[d];
    end
  endtask

  task automatic run(input vec_t v);
    clr();
    cur_base = v.base;
    base = v.base;
    len = v.len;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      start = (t == 0);
      ready = v.toggle ? (t % 2 == 0) : 1'b1;
      #1;
      mon(t);
      if (done_n[0] > 0 && done_n[1] > 0 && t >= done_t[0] + 3 && t >= done_t[1] + 3) break;
    end
    start = 1'b0;
    ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("reads", 64'(rd_n[d]), 64'(v.exp_n));
      chk("words", 64'(wd_n[d]), 64'(v.exp_n));
      chk("done_count", 64'(done_n[d]), 64'd1);
      chk("done_time", 64'(done_t[d]), v.exp_n == 0 ? 64'd1 : 64'(last_wd[d] + 1));
      chk("max_outstanding", 64'(max_out[d] <= 2), 64'd1);
      chk("err_clear", 64'(err[d]), 64'd0);
      chk("busy_end", 64'(busy[d]), 64'd0);
      if (v.exp_n == 0) chk("busy_len0", 64'(busy_seen[d]), 64'd0);
    end
    if (v.exp_span >= 0) begin
      chk("rd_span", 64'(last_rd[0] - first_rd[0]), 64'(v.exp_span));
      chk("wd_span", 64'(last_wd[0] - first_wd[0]), 64'(v.exp_span));
    end
  endtask

  task automatic chk_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk(nm, {rd_en[d], addr_w[d], vld[d], busy[d], done[d], err[d]}, 64'd0);
      chk(nm, dout_w[d], 64'd0);
    end
  endtask

  task automatic abort_test();
    int at;
    int snap [2];
    at = -1;
    snap = '{0, 0};
    clr();
    cur_base = 16'h0100;
    base = 16'h0100;
    len = 16'd6;
    ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      start = (t == 0);
      abort = (at < 0 && wd_n[0] == 2);
      if (abort) at = t;
      #1;
      mon(t);
      if (t == at) snap = rd_n;
      if (at >= 0 && t == at + 1)
        for (int d = 0; d < 2; d++) begin
          chk("abort_valid", 64'(vld[d]), 64'd0);
          chk("abort_busy", 64'(busy[d]), 64'd0);
        end
      if (at >= 0 && t > at + 10) break;
    end
    abort = 1'b0;
    start = 1'b0;
    chk("abort_hit", 64'(at >= 0), 64'd1);
    for (int d = 0; d < 2; d++) begin
      chk("abort_no_done", 64'(done_n[d]), 64'd0);
      chk("abort_no_reads", 64'(rd_n[d]), 64'(snap[d]));
    end
  endtask

  task automatic tmo_test();
    int sn;
    bit hit;
    int dn;
    sn = 0; hit = 0; dn = 0;
    base = 16'h0500;
    len = 16'd4;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      start = (t == 0);
      ready = 1'b0;
      #1;
      if (done != 2'b00) dn++;
      if (err[1]) begin
        hit = 1;
        break;
      end
      if (vld[1]) sn++;
    end
    start = 1'b0;
`ifdef RAVAN_RD_TIMEOUT_EN
    chk("tmo_err", 64'(hit), 64'd1);
    chk("tmo_stalls", 64'(sn), 64'd8);
    chk("tmo_busy", 64'(busy[1]), 64'd0);
    chk("tmo_valid", 64'(vld[1]), 64'd0);
`else
    chk("stall_no_err", 64'(hit), 64'd0);
    chk("stall_valid", 64'(vld), 64'd3);
    chk("stall_busy", 64'(busy), 64'd3);
`endif
    @(negedge clk);
    abort = 1'b1;
    #1;
    if (done != 2'b00) dn++;
    @(negedge clk);
    abort = 1'b0;
    #1;
    if (done != 2'b00) dn++;
    chk("stall_abort_valid", 64'(vld), 64'd0);
    chk("stall_abort_busy", 64'(busy), 64'd0);
`ifdef RAVAN_RD_TIMEOUT_EN
    chk("err_sticky", 64'(err), 64'd2);
`else
    chk("err_tied", 64'(err), 64'd0);
`endif
    chk("stall_no_done", 64'(dn), 64'd0);
    ready = 1'b1;
  endtask

  task automatic reset_test();
    int bad;
    bad = 0;
    clr();
    cur_base = 16'h0400;
    base = 16'h0400;
    len = 16'd10;
    ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      start = (t == 0);
      #1;
      mon(t);
    end
    start = 1'b0;
    chk("pre_reset_busy", 64'(busy), 64'd3);
    #2 rst = 1'b0;
    #1 chk_zero("reset_mid");
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      #1;
      if (done != 2'b00 || busy != 2'b00 || rd_en != 2'b00) bad++;
    end
    chk("post_reset_quiet", 64'(bad), 64'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0010, 16'd4, 1'b0, 4, 3};
    vecs[1] = '{16'hFFFE, 16'd3, 1'b0, 3, 2};
    vecs[2] = '{16'h1234, 16'd8, 1'b1, 8, -1};
    vecs[3] = '{16'h0000, 16'd0, 1'b0, 0, -1};
    vecs[4] = '{16'h7FFF, 16'd1, 1'b0, 1, 0};
    vecs[5] = '{16'hFFFF, 16'd5, 1'b1, 5, -1};
    vecs[6] = '{16'hABCD, 16'd6, 1'b0, 6, 5};
    #1 chk_zero("reset_noclk");
    @(negedge clk);
    chk_zero("reset_clk");
    rst = 1'b1;
    for (int i = 0; i < 7; i++) run(vecs[i]);
    abort_test();
    run(vecs[0]);
    tmo_test();
    run(vecs[2]);
    reset_test();
    run(vecs[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ravan_mem_reader.md
RAVAN_MEM_READER -- requirements
Module: ravan_mem_reader

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles from mem_rd_en to mem_rdata valid (legal 1..4).
REQ-002 SHALL have parameter TIMEOUT, default 255, consumer stall limit in cycles, used only under RAVAN_RD_TIMEOUT_EN.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  request a burst read; sampled only in IDLE.
REQ-006 SHALL have port abort  in  1  synchronous cancel of the current burst.
REQ-007 SHALL have port base_addr  in  16  first word address (the key-reduced address).
REQ-008 SHALL have port len  in  16  burst length in 64-bit words; 0 is legal.
REQ-009 SHALL have port mem_rd_en  out  1  one-cycle read strobe to encrypted-data memory.
REQ-010 SHALL have port mem_addr  out  16  read address, valid with mem_rd_en.
REQ-011 SHALL have port mem_rdata  in  64  read data, valid exactly MEM_LAT cycles after mem_rd_en.
REQ-012 SHALL have port dout  out  64  ciphertext word to the decryption core.
REQ-013 SHALL have port dout_valid  out  1  dout holds a word.
REQ-014 SHALL have port dout_ready  in  1  consumer accepts; transfer when dout_valid and dout_ready are both 1.
REQ-015 SHALL have port busy  out  1  high in RUN and DRAIN.
REQ-016 SHALL have port done  out  1  one-cycle completion pulse.
REQ-017 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN.
REQ-019 SHALL, in IDLE with start=1 and len!=0, latch base_addr and len and go to RUN next cycle; start outside IDLE is ignored.
REQ-020 SHALL, in IDLE with start=1 and len=0, issue no read, stay in IDLE, and pulse done on the following cycle.
REQ-021 SHALL buffer read data in a 2-entry FIFO driving dout/dout_valid, words delivered in address order.
REQ-022 SHALL issue a read in RUN only when FIFO occupancy plus reads in flight is less than 2 (no overflow, no data loss at any MEM_LAT).
REQ-023 SHALL increment mem_addr by 1 per issued read, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-024 SHALL move RUN->DRAIN the cycle after the len-th read is issued.
REQ-025 SHALL, in DRAIN, return to IDLE and pulse done in the cycle after the final word transfer with no reads in flight.
REQ-026 SHALL allow a FIFO push and pop in the same cycle, occupancy unchanged.
REQ-027 SHALL, on abort=1 in RUN or DRAIN, flush the FIFO, discard in-flight returns, deassert dout_valid next cycle, go to IDLE, and not pulse done; abort in IDLE has no effect.
REQ-028 SHALL keep dout stable while dout_valid=1 and dout_ready=0.
REQ-029 SHALL achieve a throughput of one word per cycle when MEM_LAT=1 and dout_ready is held at 1.

Reset
REQ-030 SHALL, while rst=0, force state IDLE, FIFO empty, no reads in flight, and all counters to 0.
REQ-031 SHALL drive all outputs to 0 during reset, with no clock required: mem_rd_en, mem_addr, dout, dout_valid, busy, done, err.
REQ-032 SHALL treat reset mid-burst as abort, with no done pulse after reset release.

Configuration
REQ-033 SHALL, with RAVAN_RD_TIMEOUT_EN defined, count consecutive cycles of dout_valid=1 and dout_ready=0, reset the count on any transfer, and on reaching TIMEOUT set err=1 and perform the abort action of REQ-027.
REQ-034 SHALL keep err set until the next accepted start or reset.
REQ-035 SHALL, without RAVAN_RD_TIMEOUT_EN, tie err to 0 and allow a stall to last indefinitely.

Verification
REQ-036 SHALL cover: base=0x0010, len=4, MEM_LAT=1, ready=1 -> addr 0x10..0x13 on 4 consecutive cycles, 4 words in order, done 1 cycle after last transfer.
REQ-037 SHALL cover: base=0xFFFE, len=3 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000.
REQ-038 SHALL cover: MEM_LAT=3, ready toggled 1010..., len=8 -> 8 words in order, no overflow, at most 2 in flight plus buffered.
REQ-039 SHALL cover: len=0 -> no mem_rd_en, done pulses 1 cycle after start, busy stays 0.
REQ-040 SHALL cover: abort after word 2 of len=6 -> dout_valid=0 next cycle, no done, and a new start then succeeds.
REQ-041 SHALL cover: RAVAN_RD_TIMEOUT_EN, TIMEOUT=8, ready=0 -> err=1 after 8 stalled cycles, back in IDLE, no done.
